// File: rtl/procyon_core_pkg.sv
// Shared core types for the register alias table: index, ROB tag and data types
// sized for the default configuration, plus the hardwired zero register index.
package procyon_core_pkg;

    localparam int unsigned RAT_DATA_WIDTH    = 32;
    localparam int unsigned RAT_ROB_IDX_WIDTH = 5;
    localparam int unsigned RAT_DEPTH         = 32;
    localparam int unsigned RAT_IDX_WIDTH     = $clog2(RAT_DEPTH);
    localparam int unsigned RAT_ZERO_REG      = 0;

    typedef logic [RAT_IDX_WIDTH-1:0]     rat_idx_t;
    typedef logic [RAT_ROB_IDX_WIDTH-1:0] rob_idx_t;
    typedef logic [RAT_DATA_WIDTH-1:0]    data_t;

endpackage

// File: rtl/procyon_rat_mp_entry.sv
// One RAT entry: retired data, producer tag and ready bit, updated by rename,
// multi-port retire (highest port wins) and flush, with asynchronous reset.
module procyon_rat_mp_entry
    import procyon_core_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH    = RAT_DATA_WIDTH,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = RAT_ROB_IDX_WIDTH,
    parameter int unsigned OPTN_RAT_IDX_WIDTH = RAT_IDX_WIDTH,
    parameter int unsigned OPTN_RETIRE_PORTS  = 2,
    parameter int unsigned OPTN_ENTRY_IDX     = 1
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          i_flush,
    input  logic                                          i_rename_en,
    input  logic [OPTN_RAT_IDX_WIDTH-1:0]                 i_rename_rdst,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]                 i_rename_tag,
    input  logic [OPTN_RETIRE_PORTS-1:0]                  i_retire_en,
    input  logic [OPTN_RETIRE_PORTS*OPTN_RAT_IDX_WIDTH-1:0] i_retire_rdst,
    input  logic [OPTN_RETIRE_PORTS*OPTN_DATA_WIDTH-1:0]  i_retire_data,
    input  logic [OPTN_RETIRE_PORTS*OPTN_ROB_IDX_WIDTH-1:0] i_retire_tag,
    output logic [OPTN_DATA_WIDTH-1:0]                    o_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                 o_tag,
    output logic                                          o_rdy
);

    localparam logic [OPTN_RAT_IDX_WIDTH-1:0] ENTRY_IDX = OPTN_RAT_IDX_WIDTH'(OPTN_ENTRY_IDX);

    logic [OPTN_DATA_WIDTH-1:0]    data_r;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_r;
    logic                          rdy_r;

    logic                          retire_hit;
    logic [OPTN_DATA_WIDTH-1:0]    retire_data;
    logic [OPTN_ROB_IDX_WIDTH-1:0] retire_tag;
    logic                          rename_hit;

    logic [OPTN_DATA_WIDTH-1:0]    data_n;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_n;
    logic                          rdy_n;

    // Ascending scan so the youngest (highest-indexed) matching port overrides older ones
    always_comb begin
        retire_hit  = 1'b0;
        retire_data = '0;
        retire_tag  = '0;
        for (int unsigned p = 0; p < OPTN_RETIRE_PORTS; p++) begin
            if (i_retire_en[p] && (i_retire_rdst[p*OPTN_RAT_IDX_WIDTH +: OPTN_RAT_IDX_WIDTH] == ENTRY_IDX)) begin
                retire_hit  = 1'b1;
                retire_data = i_retire_data[p*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
                retire_tag  = i_retire_tag[p*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
            end
        end
    end

    assign rename_hit = i_rename_en && (i_rename_rdst == ENTRY_IDX);

    // Priority on rdy: retire tag match, then rename clears it, then flush sets it
    always_comb begin
        data_n = data_r;
        tag_n  = tag_r;
        rdy_n  = rdy_r;
        if (retire_hit) begin
            data_n = retire_data;
            rdy_n  = (retire_tag == tag_r);
        end
        if (rename_hit) begin
            tag_n = i_rename_tag;
            rdy_n = 1'b0;
        end
        if (i_flush) begin
            rdy_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_r <= '0;
            tag_r  <= '0;
            rdy_r  <= 1'b1;
        end else begin
            data_r <= data_n;
            tag_r  <= tag_n;
            rdy_r  <= rdy_n;
        end
    end

    assign o_data = data_r;
    assign o_tag  = tag_r;
    assign o_rdy  = rdy_r;

endmodule

// File: rtl/procyon_rat_mp.sv
// Multi-ported register alias table: zero-latency source lookup, one rename and
// several retires per cycle. Define PROCYON_RAT_RETIRE_BYPASS_EN to forward same-cycle retires to lookups.
module procyon_rat_mp
    import procyon_core_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH    = 32,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = 5,
    parameter int unsigned OPTN_RAT_DEPTH     = 32,
    parameter int unsigned OPTN_RAT_SRC_PORTS = 2,
    parameter int unsigned OPTN_RETIRE_PORTS  = 2,
    localparam int unsigned IDX_W             = $clog2(OPTN_RAT_DEPTH)
) (
    input  logic                                           clk,
    input  logic                                           n_rst,
    input  logic                                           i_flush,
    input  logic [OPTN_RAT_SRC_PORTS*IDX_W-1:0]            i_rat_lookup_rsrc,
    output logic [OPTN_RAT_SRC_PORTS*OPTN_DATA_WIDTH-1:0]  o_rat_lookup_data,
    output logic [OPTN_RAT_SRC_PORTS*OPTN_ROB_IDX_WIDTH-1:0] o_rat_lookup_tag,
    output logic [OPTN_RAT_SRC_PORTS-1:0]                  o_rat_lookup_rdy,
    input  logic                                           i_rat_rename_en,
    input  logic [IDX_W-1:0]                               i_rat_rename_rdst,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]                  i_rat_rename_tag,
    input  logic [OPTN_RETIRE_PORTS-1:0]                   i_rat_retire_en,
    input  logic [OPTN_RETIRE_PORTS*IDX_W-1:0]             i_rat_retire_rdst,
    input  logic [OPTN_RETIRE_PORTS*OPTN_DATA_WIDTH-1:0]   i_rat_retire_data,
    input  logic [OPTN_RETIRE_PORTS*OPTN_ROB_IDX_WIDTH-1:0] i_rat_retire_tag
);

    logic [OPTN_DATA_WIDTH-1:0]    ent_data [OPTN_RAT_DEPTH];
    logic [OPTN_ROB_IDX_WIDTH-1:0] ent_tag  [OPTN_RAT_DEPTH];
    logic                          ent_rdy  [OPTN_RAT_DEPTH];

    // Register 0 has no storage: renames and retires to it simply have no target
    assign ent_data[RAT_ZERO_REG] = '0;
    assign ent_tag[RAT_ZERO_REG]  = '0;
    assign ent_rdy[RAT_ZERO_REG]  = 1'b1;

    for (genvar i = 1; i < OPTN_RAT_DEPTH; i++) begin : g_entry
        procyon_rat_mp_entry #(
            .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
            .OPTN_ROB_IDX_WIDTH (OPTN_ROB_IDX_WIDTH),
            .OPTN_RAT_IDX_WIDTH (IDX_W),
            .OPTN_RETIRE_PORTS  (OPTN_RETIRE_PORTS),
            .OPTN_ENTRY_IDX     (i)
        ) u_entry (
            .clk           (clk),
            .n_rst         (n_rst),
            .i_flush       (i_flush),
            .i_rename_en   (i_rat_rename_en),
            .i_rename_rdst (i_rat_rename_rdst),
            .i_rename_tag  (i_rat_rename_tag),
            .i_retire_en   (i_rat_retire_en),
            .i_retire_rdst (i_rat_retire_rdst),
            .i_retire_data (i_rat_retire_data),
            .i_retire_tag  (i_rat_retire_tag),
            .o_data        (ent_data[i]),
            .o_tag         (ent_tag[i]),
            .o_rdy         (ent_rdy[i])
        );
    end

`ifdef PROCYON_RAT_RETIRE_BYPASS_EN
    // The youngest port writing the source decides; forward only if it will make the entry ready
    always_comb begin
        o_rat_lookup_data = '0;
        o_rat_lookup_tag  = '0;
        o_rat_lookup_rdy  = '0;
        for (int unsigned s = 0; s < OPTN_RAT_SRC_PORTS; s++) begin
            logic [IDX_W-1:0]              rsrc;
            logic                          hit;
            logic [OPTN_DATA_WIDTH-1:0]    fwd_data;
            logic [OPTN_ROB_IDX_WIDTH-1:0] fwd_tag;
            rsrc     = i_rat_lookup_rsrc[s*IDX_W +: IDX_W];
            hit      = 1'b0;
            fwd_data = '0;
            fwd_tag  = '0;
            for (int unsigned p = 0; p < OPTN_RETIRE_PORTS; p++) begin
                if (i_rat_retire_en[p] && (i_rat_retire_rdst[p*IDX_W +: IDX_W] == rsrc)) begin
                    hit      = 1'b1;
                    fwd_data = i_rat_retire_data[p*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
                    fwd_tag  = i_rat_retire_tag[p*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
                end
            end
            o_rat_lookup_data[s*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH]     = ent_data[rsrc];
            o_rat_lookup_tag[s*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH] = ent_tag[rsrc];
            o_rat_lookup_rdy[s]                                          = ent_rdy[rsrc];
            if (hit && (fwd_tag == ent_tag[rsrc]) && (rsrc != IDX_W'(RAT_ZERO_REG))) begin
                o_rat_lookup_data[s*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH] = fwd_data;
                o_rat_lookup_rdy[s]                                     = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_rat_lookup_data = '0;
        o_rat_lookup_tag  = '0;
        o_rat_lookup_rdy  = '0;
        for (int unsigned s = 0; s < OPTN_RAT_SRC_PORTS; s++) begin
            o_rat_lookup_data[s*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH]     = ent_data[i_rat_lookup_rsrc[s*IDX_W +: IDX_W]];
            o_rat_lookup_tag[s*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH] = ent_tag[i_rat_lookup_rsrc[s*IDX_W +: IDX_W]];
            o_rat_lookup_rdy[s]                                          = ent_rdy[i_rat_lookup_rsrc[s*IDX_W +: IDX_W]];
        end
    end
`endif

endmodule

// File: doc/procyon_rat_mp.md
Name: procyon_rat_mp

Overview:
- Multi-ported Register Alias Table: OPTN_RAT_DEPTH architectural registers, each holding retired data, producing ROB tag and ready bit.
- Sits between dispatch and the ROB.
  - Dispatch looks up source operands and renames one destination per cycle.
  - The ROB retires up to OPTN_RETIRE_PORTS instructions per cycle and flushes on exception or mispredict.
- Register 0 is hardwired to zero and always ready.

Parameters:
- OPTN_DATA_WIDTH, 32, register data width
- OPTN_ROB_IDX_WIDTH, 5, ROB tag width
- OPTN_RAT_DEPTH, 32, number of architectural registers (power of 2, >=2)
- OPTN_RAT_SRC_PORTS, 2, number of source lookup ports
- OPTN_RETIRE_PORTS, 2, number of retire/writeback ports; a higher index means a younger instruction

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  set every ready bit
- i_rat_lookup_rsrc  in  SRC_PORTS x log2(DEPTH)  source register indices
- o_rat_lookup_data  out  SRC_PORTS x DATA_WIDTH  source data
- o_rat_lookup_tag  out  SRC_PORTS x ROB_IDX_WIDTH  source producer tag
- o_rat_lookup_rdy  out  SRC_PORTS x 1  source data valid
- i_rat_rename_en  in  1  rename destination
- i_rat_rename_rdst  in  log2(DEPTH)  destination register
- i_rat_rename_tag  in  ROB_IDX_WIDTH  new producer tag
- i_rat_retire_en  in  RETIRE_PORTS x 1  retire valid per port
- i_rat_retire_rdst  in  RETIRE_PORTS x log2(DEPTH)  retiring destination
- i_rat_retire_data  in  RETIRE_PORTS x DATA_WIDTH  retired value
- i_rat_retire_tag  in  RETIRE_PORTS x ROB_IDX_WIDTH  retiring ROB tag

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, n_rst.
- Reset values:
  - every entry: data=0, tag=0, rdy=1.
  - lookup outputs then reflect reset state: data 0, tag 0, rdy 1.
- Lookup:
  - Combinational read of registered state, zero latency.
  - Returns pre-update state, so rename or retire in the same cycle is not visible (except the bypass feature).
  - A source equal to the same-cycle rename destination sees the old mapping.
- Register 0:
  - Renames and retires targeting it are ignored.
  - Lookup always returns data=0, tag=0, rdy=1.
- Rename: when i_rat_rename_en, the entry's tag <= i_rat_rename_tag and rdy <= 0 on the next edge.
- Retire, per entry:
  - Select the highest-indexed port p with retire_en[p] and rdst[p]==entry.
  - data <= retire_data[p].
  - rdy <= (retire_tag[p]==tag_r).
  - Lower matching ports are discarded.
- Rename and retire to the same entry in one cycle:
  - data is written from retire.
  - tag is written from rename.
  - rdy=0.
- Flush:
  - Every rdy <= 1 next edge, overriding rename and retire rdy results.
  - Tag and data updates in the flush cycle still occur.
  - A rename in the flush cycle therefore leaves rdy=1 with the new tag.
- Tag match in retire uses the registered tag only, never the same-cycle rename tag.
- Reset asserted mid-operation: all entries return to reset values immediately, independent of clk.

Optional Feature:
- Macro: PROCYON_RAT_RETIRE_BYPASS_EN.
- Defined: each lookup port forwards same-cycle retires. If some retire port p (highest index wins) has rdst==rsrc, retire_tag[p]==tag_r, and the entry is not register 0:
  - lookup data = retire_data[p]
  - lookup rdy = 1
  - Forwarding is suppressed if the same-cycle rename targets that register? No — lookup precedes rename, so forwarding still applies.
- Undefined: lookup is purely registered state, as above.

Decomposition:
- procyon_core_pkg: add typedefs
  - rat_idx_t (log2 DEPTH bits)
  - rob_idx_t
  - data_t
  - RAT_ZERO_REG localparam = 0
- Sub-module procyon_rat_mp_entry: one entry with multi-port retire select, rename, flush, and async reset.
  - Top level generates DEPTH-1 entries plus the hardwired zero entry and the lookup muxes.

Test Plan:
- Reset: assert n_rst=0 mid-cycle after prior renames -> all lookups of r1..r31 return data=0, tag=0, rdy=1 immediately.
- Rename/retire match: rename r5 tag 7, next cycle retire port0 r5 tag 7 data 0xDEAD -> lookup r5 rdy=1, data=0xDEAD, tag=7.
- Stale retire:
  - rename r5 tag 7, then rename r5 tag 9; retire r5 tag 7 data 0x11 -> data=0x11, rdy=0, tag=9.
  - Then retire tag 9 data 0x22 -> rdy=1, data=0x22.
- Dual retire same reg: port0 r3 tag 2 data 0xA, port1 r3 tag 4 data 0xB, entry tag 4 -> data=0xB, rdy=1.
- Rename+retire+flush collision:
  - rename r6 tag 3 while retire r6 tag 1 data 0x55 -> tag=3, data=0x55, rdy=0.
  - Next cycle rename r7 tag 8 with i_flush=1 -> r6 and r7 rdy=1, r7 tag=8.
- Register 0 and bypass:
  - rename r0 tag 5, retire r0 data 0xFF -> lookup r0 returns 0, rdy=1.
  - With PROCYON_RAT_RETIRE_BYPASS_EN: r4 tag 6 pending, same-cycle retire r4 tag 6 data 0x77 -> lookup r4 data=0x77, rdy=1 in that cycle.
